// File: rtl/mm_uart_defs.sv
// mm_uart_tx shared definitions: register map, bit positions, FSM encoding.
// Kept in one place so firmware headers can be generated from it.
package mm_uart_defs;

  localparam logic [31:0] MM_UART_BASE = 32'h8000_0200;
  localparam int          MM_UART_IRQ  = 4;

  localparam logic [3:0] A_DATA   = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h4;
  localparam logic [3:0] A_DIV    = 4'h8;
  localparam logic [3:0] A_CTRL   = 4'hC;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_LVL   = 4;

  localparam int CT_IRQEN = 0;
  localparam int CT_TXEN  = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO for the UART transmitter: pointer + count, power-of-two depth.
// A push while full is accepted when a pop happens on the same edge.
module uart_fifo #(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [7:0]  wdata_i,
  output logic [7:0]  rdata_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] level_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rp_q];
  assign level_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push & ~do_pop)
      cnt_d = cnt_q + (AW+1)'(1);
    else if (do_pop & ~do_push)
      cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata_i;
  end

endmodule

// File: rtl/mm_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, baud divisor and irq.
// Bus accesses complete with a one-cycle ready strobe; one effect per access.
module mm_uart_tx
  import mm_uart_defs::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd233
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        select,
  input  logic [3:0]  wstrb,
  input  logic [3:0]  addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic [31:0] data_o,
  output logic        txd,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  tx_state_e   state_q, state_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        ovf_q, ovf_d;
  logic        irq_en_q, irq_en_d;
  logic        tx_en_q, tx_en_d;
  logic        irq_q;

  logic        push, pop;
  logic        f_full, f_empty;
  logic [7:0]  f_rdata;
  logic [AW:0] f_level;
  logic        wr, busy, tick, can_pop;
  logic [31:0] rd;
  logic        unused_hi;

  assign wr        = ready_q & (wstrb != 4'b0);
  assign push      = wr & wstrb[0] & (addr == A_DATA);
  assign busy      = state_q != S_IDLE;
  assign tick      = cnt_q == 16'd0;
  assign can_pop   = ~f_empty & tx_en_q;
  assign unused_hi = ^data_i[31:16];

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (data_i[7:0]),
    .rdata_o (f_rdata),
    .full_o  (f_full),
    .empty_o (f_empty),
    .level_o (f_level)
  );

  // done_q blocks a second ready while the master keeps select high
  always_comb begin
    ready_d  = select & ~ready_q & ~done_q;
    done_d   = select & (ready_q | done_q);
    ovf_d    = ovf_q;
    div_d    = div_q;
    irq_en_d = irq_en_q;
    tx_en_d  = tx_en_q;
    if (wr) begin
      unique case (1'b1)
        addr == A_STATUS: begin
          if (wstrb[0] & data_i[ST_OVF]) ovf_d = 1'b0;
        end
        addr == A_DIV: begin
          if (wstrb[0]) div_d[7:0]  = data_i[7:0];
          if (wstrb[1]) div_d[15:8] = data_i[15:8];
        end
        addr == A_CTRL: begin
          if (wstrb[0]) begin
            irq_en_d = data_i[CT_IRQEN];
            tx_en_d  = data_i[CT_TXEN];
          end
        end
        default: ;
      endcase
    end
    if (push & f_full & ~pop) ovf_d = 1'b1;
  end

  always_comb begin
    rd = '0;
    if (ready_q) begin
      unique case (1'b1)
        addr == A_STATUS: begin
          rd[ST_BUSY]     = busy;
          rd[ST_FULL]     = f_full;
          rd[ST_EMPTY]    = f_empty;
          rd[ST_OVF]      = ovf_q;
          rd[ST_LVL +: 4] = 4'(f_level);
        end
        addr == A_DIV: rd[15:0] = div_q;
        addr == A_CTRL: begin
          rd[CT_IRQEN] = irq_en_q;
          rd[CT_TXEN]  = tx_en_q;
        end
        default: ;
      endcase
    end
  end

  // divisor is sampled only on reload, so a new value waits for a bit edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          state_d = S_START;
          cnt_d   = div_q;
          sh_d    = f_rdata;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          cnt_d   = div_q;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d = div_q;
          sh_d  = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d = div_q;
          if (can_pop) begin
            pop     = 1'b1;
            state_d = S_START;
            sh_d    = f_rdata;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      div_q    <= DIV_RESET;
      irq_en_q <= 1'b0;
      tx_en_q  <= 1'b1;
      irq_q    <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
    end else begin
      ready_q  <= ready_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      irq_en_q <= irq_en_d;
      tx_en_q  <= tx_en_d;
      irq_q    <= irq_en_q & f_empty & ~busy;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
    end
  end

  assign ready  = ready_q;
  assign data_o = rd;
  assign irq    = irq_q;
  assign txd    = (state_q == S_START) ? 1'b0 :
                  (state_q == S_DATA)  ? sh_q[0] : 1'b1;

endmodule

// File: tb/tb_mm_uart_tx.sv
// Bench for mm_uart_tx: frame-level reference model plus directed literals.
`timescale 1ns/1ps
module tb_mm_uart_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        select = 1'b0;
  logic [3:0]  wstrb = '0;
  logic [3:0]  addr = '0;
  logic [31:0] data_i = '0;
  logic        ready;
  logic [31:0] data_o;
  logic        txd;
  logic        irq;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mm_uart_tx dut (
    .clk     (clk),
    .reset_n (reset_n),
    .select  (select),
    .wstrb   (wstrb),
    .addr    (addr),
    .data_i  (data_i),
    .ready   (ready),
    .data_o  (data_o),
    .txd     (txd),
    .irq     (irq)
  );

  function automatic void chk(string nm, longint unsigned act,
                              longint unsigned exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: byte queue, frame as a queue of line levels,
  // remaining clocks in the current bit.
  logic [7:0]  mq[$];
  bit          fb[$];
  int          rem;
  bit          m_busy, m_ovf, m_ien, m_ten, m_irq, m_rdy, m_done;
  logic [15:0] m_div;

  function automatic void model_step();
    bit          do_pop, irq_n, rdy_n, done_n;
    logic [15:0] odiv;
    logic [7:0]  b;
    odiv   = m_div;
    irq_n  = m_ien && (mq.size() == 0) && !m_busy;
    do_pop = 1'b0;
    if (!m_busy || (rem == 1 && fb.size() == 1))
      do_pop = (mq.size() != 0) && m_ten;
    if (m_busy) begin
      if (rem > 1) rem--;
      else begin
        void'(fb.pop_front());
        rem = int'(odiv) + 1;
        if (fb.size() == 0) m_busy = 1'b0;
      end
    end
    if (do_pop) begin
      b = mq.pop_front();
      fb.delete();
      fb.push_back(1'b0);
      for (int i = 0; i < 8; i++) fb.push_back(b[i]);
      fb.push_back(1'b1);
      rem    = int'(odiv) + 1;
      m_busy = 1'b1;
    end
    if (m_rdy && wstrb != 4'b0) begin
      case (addr)
        4'h0: if (wstrb[0]) begin
          if (mq.size() < 4) mq.push_back(data_i[7:0]);
          else m_ovf = 1'b1;
        end
        4'h4: if (wstrb[0] && data_i[3]) m_ovf = 1'b0;
        4'h8: begin
          if (wstrb[0]) m_div[7:0]  = data_i[7:0];
          if (wstrb[1]) m_div[15:8] = data_i[15:8];
        end
        4'hC: if (wstrb[0]) begin
          m_ien = data_i[0];
          m_ten = data_i[1];
        end
        default: ;
      endcase
    end
    rdy_n  = select && !m_rdy && !m_done;
    done_n = select && (m_rdy || m_done);
    m_rdy  = rdy_n;
    m_done = done_n;
    m_irq  = irq_n;
  endfunction

  function automatic logic [31:0] exp_rdata();
    logic [31:0] v;
    v = '0;
    if (m_rdy) begin
      case (addr)
        4'h4: v = {24'b0, 4'(mq.size()), m_ovf, mq.size() == 0,
                   mq.size() == 4, m_busy};
        4'h8: v = {16'b0, m_div};
        4'hC: v = {30'b0, m_ten, m_ien};
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      fb.delete();
      rem    = 0;
      m_busy = 1'b0;
      m_ovf  = 1'b0;
      m_ien  = 1'b0;
      m_ten  = 1'b1;
      m_irq  = 1'b0;
      m_rdy  = 1'b0;
      m_done = 1'b0;
      m_div  = 16'd233;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("txd", txd, m_busy ? fb[0] : 1'b1);
      chk("irq", irq, m_irq);
      chk("ready", ready, m_rdy);
      chk("data_o", data_o, exp_rdata());
    end
  end

  bit prev_txd = 1'b1;
  int runlen = 0;
  int runs[$];
  int rdy_cnt = 0;

  always @(negedge clk) begin
    if (ready) rdy_cnt++;
    if (txd !== prev_txd) begin
      runs.push_back(runlen);
      runlen   = 1;
      prev_txd = txd;
    end else begin
      runlen++;
    end
  end

  task automatic bus(input logic [3:0] a, input logic [3:0] s,
                     input logic [31:0] d, input int hold,
                     output logic [31:0] rdv);
    int k;
    @(negedge clk);
    select = 1'b1;
    addr   = a;
    wstrb  = s;
    data_i = d;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!ready && k < 8);
    chk("bus_ready", ready, 1'b1);
    rdv = data_o;
    repeat (hold) @(negedge clk);
    @(negedge clk);
    select = 1'b0;
  endtask

  task automatic wait_txd_low(string nm);
    int k;
    k = 0;
    while (txd !== 1'b0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(nm, txd, 1'b0);
  endtask

  logic [31:0] rdv;
  logic [39:0] cap;
  logic [3:0]  ra, rs;
  logic [31:0] rdat;
  int          k, c0;
  int          exp_runs[9] = '{4, 4, 8, 8, 8, 8, 8, 8, 8};

  initial begin
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;

    bus(4'h4, 4'h0, 0, 0, rdv);
    chk("reset_status", rdv, 32'h04);
    bus(4'h8, 4'h0, 0, 0, rdv);
    chk("reset_div", rdv, 32'd233);
    bus(4'hC, 4'h0, 0, 0, rdv);
    chk("reset_ctrl", rdv, 32'h2);

    // 0x55 at divisor 3
    bus(4'h8, 4'h3, 32'd3, 0, rdv);
    bus(4'h0, 4'h1, 32'h55, 0, rdv);
    wait_txd_low("frame55_start");
    cap = '0;
    for (int i = 0; i < 40; i++) begin
      cap = {cap[38:0], txd};
      @(negedge clk);
    end
    chk("frame55_bits", cap, 40'h0F0F0F0F0F);
    repeat (4) @(negedge clk);

    // irq timing
    bus(4'hC, 4'h1, 32'h3, 0, rdv);
    repeat (3) @(negedge clk);
    chk("irq_idle", irq, 1'b1);
    bus(4'h0, 4'h1, 32'hA5, 0, rdv);
    wait_txd_low("irq_frame_start");
    k = 0;
    while (!irq && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("irq_delay", k, 41);

    // overflow on the sixth back-to-back write
    for (int i = 0; i < 6; i++) bus(4'h0, 4'h1, 32'h10 + i, 0, rdv);
    bus(4'h4, 4'h0, 0, 0, rdv);
    chk("ovf_status", rdv, 32'h4B);
    bus(4'h4, 4'h1, 32'h8, 0, rdv);
    bus(4'h4, 4'h0, 0, 0, rdv);
    chk("ovf_cleared", rdv, 32'h43);
    repeat (220) @(negedge clk);

    // select held for several cycles
    @(negedge clk);
    #1 c0 = rdy_cnt;
    bus(4'h4, 4'h0, 0, 4, rdv);
    chk("held_status", rdv, 32'h04);
    repeat (3) @(negedge clk);
    #1 chk("held_ready_once", rdy_cnt - c0, 1);

    // divisor change mid data bit
    @(negedge clk);
    runs.delete();
    bus(4'h0, 4'h1, 32'h55, 0, rdv);
    wait_txd_low("div_frame_start");
    repeat (4) @(negedge clk);
    bus(4'h8, 4'h3, 32'd7, 0, rdv);
    repeat (90) @(negedge clk);
    chk("div_runs_count", runs.size() >= 10, 1'b1);
    if (runs.size() >= 10)
      for (int i = 0; i < 9; i++) chk($sformatf("div_run%0d", i), runs[i+1], exp_runs[i]);

    // reset in the middle of a frame
    bus(4'h8, 4'h3, 32'd3, 0, rdv);
    bus(4'h0, 4'h1, 32'h00, 0, rdv);
    bus(4'h0, 4'h1, 32'h00, 0, rdv);
    wait_txd_low("rst_frame_start");
    repeat (8) @(negedge clk);
    chk("rst_pre_txd", txd, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_txd", txd, 1'b1);
    chk("rst_ready", ready, 1'b0);
    chk("rst_data_o", data_o, 32'h0);
    chk("rst_irq", irq, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    bus(4'h4, 4'h0, 0, 0, rdv);
    chk("rst_status", rdv, 32'h04);
    bus(4'h8, 4'h0, 0, 0, rdv);
    chk("rst_div", rdv, 32'd233);

    // randomized traffic, small divisors
    bus(4'h8, 4'h3, 32'd2, 0, rdv);
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: ra = 4'h0;
        3:       ra = 4'h4;
        4:       ra = 4'h8;
        5:       ra = 4'hC;
        6:       ra = 4'($urandom_range(0, 15));
        default: ra = 4'h0;
      endcase
      rs   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rdat = $urandom;
      if (ra == 4'h8) rdat = $urandom_range(0, 3);
      if (ra == 4'hC) rdat[1] = ($urandom_range(0, 3) != 0);
      bus(ra, rs, rdat, $urandom_range(0, 2), rdv);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    bus(4'hC, 4'h1, 32'h3, 0, rdv);
    bus(4'h4, 4'h1, 32'h8, 0, rdv);
    repeat (300) @(negedge clk);
    bus(4'h4, 4'h0, 0, 0, rdv);
    chk("final_status", rdv, 32'h04);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
